// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the instruction-fetch path
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HOLD,
        ST_ERROR
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] ALIGN_MASK       = 32'(INSTR_BYTES - 1);

    // A PC is usable only if it sits on an instruction-word boundary.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr & ALIGN_MASK) == 32'h0;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - bounded wait counter for instruction-memory acknowledgements
module fetch_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] count;

    // Count waiting cycles; saturate at the limit so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and multi-cycle instruction fetch controller
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins_addr,
    output logic [31:0] ins,
    output logic        ins_valid,
    input  logic        ins_done,
    input  logic [31:0] next_ins_addr,
    input  logic        stall,
    output logic        fetch_err,
    output logic [31:0] retired_cnt
);

    fetch_state_t state, state_nxt;
    logic         wd_expired;
    logic         in_fetch;
    logic         commit;

    assign in_fetch = (state == ST_FETCH);
    assign commit   = (state == ST_EXEC) && ins_done;

    // Watchdog sits at zero outside FETCH, so every FETCH entry starts a fresh window.
    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_fetch),
        .enable  (in_fetch && !imem_ack),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack in the expiry cycle takes priority over the fault.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = stall ? ST_HOLD : ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    state_nxt = ST_EXEC;
                end else if (wd_expired) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_EXEC: begin
                if (ins_done) begin
                    if (!is_aligned(next_ins_addr)) begin
                        state_nxt = ST_ERROR;
                    end else if (stall) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_HOLD:  state_nxt = stall ? ST_HOLD : ST_FETCH;
            ST_ERROR: state_nxt = ST_ERROR;
            default:  state_nxt = ST_ERROR;
        endcase
    end

    // PC, instruction holding register and retirement counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_addr    <= RESET_PC;
            ins         <= '0;
            retired_cnt <= '0;
        end else begin
            if (in_fetch && imem_ack) begin
                ins <= imem_rdata;
            end
            if (commit) begin
                ins_addr    <= next_ins_addr;
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end

    // Moore outputs; reset forces IDLE, so the request drops asynchronously.
    assign imem_req  = in_fetch;
    assign imem_addr = ins_addr;
    assign ins_valid = (state == ST_EXEC);
    assign fetch_err = (state == ST_ERROR);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ins_addr;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ins_done;
    logic [31:0] next_ins_addr;
    logic        stall;
    logic        fetch_err;
    logic [31:0] retired_cnt;

    int checks;
    int failures;

    fetch_sequencer #(
        .RESET_PC (32'h0000_3000),
        .TIMEOUT  (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .ins_addr      (ins_addr),
        .ins           (ins),
        .ins_valid     (ins_valid),
        .ins_done      (ins_done),
        .next_ins_addr (next_ins_addr),
        .stall         (stall),
        .fetch_err     (fetch_err),
        .retired_cnt   (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req"},     32'(imem_req),    32'd0);
        check_eq({tag, "_addr"},    ins_addr,         32'h0000_3000);
        check_eq({tag, "_ins"},     ins,              32'h0);
        check_eq({tag, "_valid"},   32'(ins_valid),   32'd0);
        check_eq({tag, "_err"},     32'(fetch_err),   32'd0);
        check_eq({tag, "_retired"}, retired_cnt,      32'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        ins_done      = 1'b0;
        next_ins_addr = 32'h0;
        stall         = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_reset_values("rst");

        // Zero-wait ack on the very first request
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        rst_n      = 1'b1;
        step();
        check_eq("c1_req",  32'(imem_req), 32'd1);
        check_eq("c1_addr", imem_addr,     32'h0000_3000);
        step();
        imem_ack = 1'b0;
        check_eq("c2_valid", 32'(ins_valid), 32'd1);
        check_eq("c2_ins",   ins,            32'h2008_0005);
        check_eq("c2_req",   32'(imem_req),  32'd0);

        // Sequential commit
        ins_done      = 1'b1;
        next_ins_addr = 32'h0000_3004;
        step();
        ins_done = 1'b0;
        check_eq("seq_addr",    imem_addr,       32'h0000_3004);
        check_eq("seq_req",     32'(imem_req),   32'd1);
        check_eq("seq_retired", retired_cnt,     32'd1);
        check_eq("seq_valid",   32'(ins_valid),  32'd0);

        // Branch redirect
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_2222;
        step();
        imem_ack = 1'b0;
        check_eq("br_ins", ins, 32'h1111_2222);
        ins_done      = 1'b1;
        next_ins_addr = 32'h0000_3040;
        step();
        ins_done = 1'b0;
        check_eq("br_addr",    imem_addr,     32'h0000_3040);
        check_eq("br_req",     32'(imem_req), 32'd1);
        check_eq("br_retired", retired_cnt,   32'd2);

        // Stall raised during FETCH keeps the request up
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("fst_req",  32'(imem_req), 32'd1);
            check_eq("fst_addr", imem_addr,     32'h0000_3040);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_4444;
        step();
        imem_ack = 1'b0;
        check_eq("fst_valid", 32'(ins_valid), 32'd1);
        check_eq("fst_ins",   ins,            32'h3333_4444);

        // Stall at ins_done: three cycles in HOLD, then fetch at committed PC
        ins_done      = 1'b1;
        next_ins_addr = 32'h0000_3044;
        step();
        ins_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_req",   32'(imem_req),  32'd0);
            check_eq("hold_valid", 32'(ins_valid), 32'd0);
            if (i < 2) step();
        end
        stall = 1'b0;
        step();
        check_eq("hold_rel_req",  32'(imem_req), 32'd1);
        check_eq("hold_rel_addr", imem_addr,     32'h0000_3044);
        check_eq("hold_retired",  retired_cnt,   32'd3);

        // Misaligned target faults and stays faulted
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_6666;
        step();
        imem_ack      = 1'b0;
        ins_done      = 1'b1;
        next_ins_addr = 32'h0000_3006;
        step();
        check_eq("mis_err",     32'(fetch_err), 32'd1);
        check_eq("mis_addr",    ins_addr,       32'h0000_3006);
        check_eq("mis_req",     32'(imem_req),  32'd0);
        check_eq("mis_retired", retired_cnt,    32'd4);
        imem_ack      = 1'b1;
        next_ins_addr = 32'h0000_3008;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("err_req",   32'(imem_req),  32'd0);
            check_eq("err_flag",  32'(fetch_err), 32'd1);
            check_eq("err_valid", 32'(ins_valid), 32'd0);
            check_eq("err_addr",  ins_addr,       32'h0000_3006);
        end
        imem_ack = 1'b0;
        ins_done = 1'b0;

        // Reset clears the fault
        rst_n = 1'b0;
        #1;
        check_reset_values("rst2");
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset during a FETCH wait
        step();
        step();
        step();
        check_eq("ar_req_before", 32'(imem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("ar");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("ar_rec_req",  32'(imem_req), 32'd1);
        check_eq("ar_rec_addr", imem_addr,     32'h0000_3000);

        // Watchdog: no ack for 16 waiting cycles faults on the 17th
        for (int i = 0; i < 15; i++) step();
        check_eq("wd_c16_err", 32'(fetch_err), 32'd0);
        check_eq("wd_c16_req", 32'(imem_req),  32'd1);
        step();
        check_eq("wd_c17_err",  32'(fetch_err), 32'd1);
        check_eq("wd_c17_req",  32'(imem_req),  32'd0);
        check_eq("wd_c17_addr", ins_addr,       32'h0000_3000);

        // Watchdog: ack in the 16th waiting cycle wins
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 15; i++) step();
        check_eq("wda_c16_req", 32'(imem_req), 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hAABB_CCDD;
        step();
        imem_ack = 1'b0;
        check_eq("wda_err",   32'(fetch_err), 32'd0);
        check_eq("wda_valid", 32'(ins_valid), 32'd1);
        check_eq("wda_ins",   ins,            32'hAABB_CCDD);
        step();
        check_eq("wda_hold_valid", 32'(ins_valid), 32'd1);
        check_eq("wda_hold_err",   32'(fetch_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch controller that owns the program counter and sequences the next-PC datapath. It issues instruction-memory reads on a req/ack handshake and holds the fetched instruction for the execute stage. When execute reports completion, it commits the next-PC value computed by `npc`. It also enforces word alignment, bounds memory latency with a watchdog, and counts retired instructions.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset.
- `TIMEOUT`, default 15: maximum cycles spent waiting for `imem_ack` before declaring a fault.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  read address; always equals `ins_addr`.
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `ins_addr`  out  32  current PC; feeds `npc.ins_addr`.
- `ins`  out  32  held instruction register.
- `ins_valid`  out  1  `ins` is valid for execute.
- `ins_done`  in  1  single-cycle pulse: execute finished the held instruction.
- `next_ins_addr`  in  32  output of `npc`; sampled only on an accepted `ins_done`.
- `stall`  in  1  hazard hold; blocks issue of a new fetch.
- `fetch_err`  out  1  sticky fault flag.
- `retired_cnt`  out  32  count of retired instructions.

## Operation
- FSM states: IDLE, FETCH, EXEC, HOLD, ERROR. All outputs are registered or Moore-decoded from state.
- IDLE: goes to FETCH when `stall`=0, otherwise to HOLD.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`ins_addr`. Both stay stable until ack; the request is never withdrawn, and `stall` has no effect while in FETCH.
  - On `imem_ack`: `ins` <= `imem_rdata`, go to EXEC.
- EXEC:
  - `ins_valid`=1.
  - On `ins_done`: `ins_addr` <= `next_ins_addr`, `retired_cnt` += 1 (wraps 2^32-1 -> 0), `ins_valid` drops.
  - Next state on `ins_done`: ERROR if `next_ins_addr[1:0]`!=0; else HOLD if `stall`; else FETCH.
- HOLD: goes to FETCH in the first cycle `stall`=0.
- ERROR:
  - Terminal until reset. `fetch_err`=1, `imem_req`=0, `ins_valid`=0.
  - `ins_addr` keeps the faulting value.
- Watchdog:
  - Counter of width $clog2(TIMEOUT+1). It clears on FETCH entry and increments on each FETCH cycle without ack.
  - When it equals TIMEOUT and `imem_ack`=0, go to ERROR. An ack arriving in that same cycle wins.
- Ignored inputs: `imem_ack` outside FETCH and `ins_done` outside EXEC.

## Timing
- Reset values (async assert): `ins_addr`=RESET_PC, `ins`=0, `ins_valid`=0, `imem_req`=0, `fetch_err`=0, `retired_cnt`=0, state IDLE, watchdog=0.
- After `rst_n` release:
  - First edge: IDLE -> FETCH.
  - `imem_req` is high from cycle 1.
- A zero-wait ack (same cycle as req) is legal. Ack in cycle N gives `ins_valid`=1 in N+1.
- `ins_done` in cycle M: new `ins_addr` and `imem_req` are visible in M+1. Best-case throughput is one instruction per 2 cycles.
- Timeout: with `TIMEOUT`=15 and no ack, `fetch_err` rises on the 17th cycle of FETCH (edge after the 16th waiting cycle).
- `rst_n` asserted mid-request: `imem_req` drops asynchronously. The memory must abandon the transaction.

## Structure
- Package `cpu_pkg`:
  - state enum `fetch_state_t`.
  - `RESET_PC_DEFAULT` = 32'h0000_3000.
  - `INSTR_BYTES` = 4.
- Sub-module `fetch_watchdog`: clear/enable inputs, `expired` output, parameterised by TIMEOUT.
- `npc` stays external and combinational. This block only samples `npc`'s output, `next_ins_addr`.

## Test plan
- Reset, then ack with 0 wait and rdata 32'h2008_0005: `imem_addr`=32'h0000_3000 in cycle 1, `ins`=32'h2008_0005 with `ins_valid` in cycle 2. Then `ins_done` with `next_ins_addr`=32'h0000_3004 gives `imem_addr`=32'h0000_3004 and `retired_cnt`=1.
- Branch redirect: `ins_done` with `next_ins_addr`=32'h0000_3040 -> next request at 32'h0000_3040.
- Stall:
  - `stall`=1 held 3 cycles at `ins_done` -> state HOLD, `imem_req`=0 for 3 cycles, then req at the committed PC.
  - `stall` raised during FETCH -> req held until ack.
- Misaligned `next_ins_addr`=32'h0000_3006 -> `fetch_err`=1, `ins_addr`=32'h0000_3006, `imem_req` stays 0 until reset.
- Watchdog:
  - No ack for 16 waiting cycles -> `fetch_err`=1.
  - Ack on exactly the 16th waiting cycle -> normal EXEC, no fault.
- Async reset asserted during FETCH wait -> outputs return to reset values immediately; recovery fetch at 32'h0000_3000.
